// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter and access sequencer for a single-port memory
// with async read and sync write. Each access runs IDLE -> ACCESS -> DONE.
module mem_arbiter #(
    parameter int A = 12,
    parameter int m = 16
) (
    input  logic         CLK,
    input  logic         rst_n,
    input  logic         req0,
    input  logic         req1,
    input  logic         we0,
    input  logic         we1,
    input  logic [A-1:0] addr0,
    input  logic [A-1:0] addr1,
    input  logic [m-1:0] wdata0,
    input  logic [m-1:0] wdata1,
    output logic         ack0,
    output logic         ack1,
    output logic [m-1:0] rdata0,
    output logic [m-1:0] rdata1,
    output logic         busy,
    output logic         gnt,
    output logic [A-1:0] mem_addr,
    output logic [m-1:0] mem_wdata,
    output logic         mem_we,
    output logic         mem_re,
    input  logic [m-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t       state_q, state_d;
    logic         gnt_q, gnt_d;
    logic [A-1:0] addr_q, addr_d;
    logic [m-1:0] wdata_q, wdata_d;
    logic         mem_we_q, mem_we_d;
    logic         mem_re_q, mem_re_d;
    logic         ack0_q, ack0_d;
    logic         ack1_q, ack1_d;
    logic [m-1:0] rdata0_q, rdata0_d;
    logic [m-1:0] rdata1_q, rdata1_d;
    logic         winner;
    logic         win_we;

    // With both ports requesting, the port that was not granted last wins.
    assign winner = (req0 && req1) ? ~gnt_q : req1;
    assign win_we = winner ? we1 : we0;

    always_comb begin
        // NOTE: every _d gets a default before the case so no path leaves it
        // unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        gnt_d    = gnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        mem_we_d = 1'b0;
        mem_re_d = 1'b0;
        ack0_d   = 1'b0;
        ack1_d   = 1'b0;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;

        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    gnt_d    = winner;
                    addr_d   = winner ? addr1 : addr0;
                    wdata_d  = winner ? wdata1 : wdata0;
                    mem_we_d = win_we;
                    mem_re_d = ~win_we;
                    state_d  = ACCESS;
                end
            end
            ACCESS: begin
                // mem_rdata is only captured here, so X outside the window never lands.
                if (mem_re_q) begin
                    if (gnt_q) rdata1_d = mem_rdata;
                    else       rdata0_d = mem_rdata;
                end
                ack0_d  = ~gnt_q;
                ack1_d  = gnt_q;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            gnt_q    <= 1'b1;
            addr_q   <= '0;
            wdata_q  <= '0;
            mem_we_q <= 1'b0;
            mem_re_q <= 1'b0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            mem_we_q <= mem_we_d;
            mem_re_q <= mem_re_d;
            ack0_q   <= ack0_d;
            ack1_q   <= ack1_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign gnt       = gnt_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = mem_we_q;
    assign mem_re    = mem_re_q;
    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign rdata0    = rdata0_q;
    assign rdata1    = rdata1_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed accesses push expected acks,
// a negedge monitor pops and compares whenever an ack appears.
module tb_mem_arbiter;

    logic        CLK;
    logic        rst_n;
    logic        req0, req1, we0, we1;
    logic [11:0] addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        ack0, ack1;
    logic [15:0] rdata0, rdata1;
    logic        busy, gnt;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we, mem_re;
    logic [15:0] mem_rdata;

    logic [15:0] mem [0:4095];

    typedef struct {
        bit          port;
        logic [15:0] rd;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    mem_arbiter #(.A(12), .m(16)) dut (
        .CLK(CLK), .rst_n(rst_n),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .busy(busy), .gnt(gnt),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Memory: async read, write on the rising edge.
    assign mem_rdata = mem[mem_addr];
    always @(posedge CLK) if (mem_we) mem[mem_addr] <= mem_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (rst_n) begin
            check("ack_exclusive", {31'b0, ack0 && ack1}, 32'd0);
            check("we_re_exclusive", {31'b0, mem_we && mem_re}, 32'd0);
            if (ack0 || ack1) begin
                if (sb.size() == 0) begin
                    check("unexpected_ack", {30'b0, ack1, ack0}, 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    check("ack_gnt", {31'b0, gnt}, {31'b0, mon_e.port});
                    check("ack_port", {31'b0, mon_e.port ? ack1 : ack0}, 32'd1);
                    check("ack_rdata", {16'b0, mon_e.port ? rdata1 : rdata0}, {16'b0, mon_e.rd});
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge CLK);
        rst_n = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        #1;
        check("rst_gnt", {31'b0, gnt}, 32'd1);
        check("rst_outs", {26'b0, ack0, ack1, busy, mem_we, mem_re, 1'b0}, 32'd0);
        check("rst_rdata", {rdata1, rdata0}, 32'd0);
        check("rst_mem_addr", {20'b0, mem_addr}, 32'd0);
        @(negedge CLK);
        rst_n = 1'b1;
        sb.delete();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 10 && busy; i++) @(negedge CLK);
        check("wait_idle", {31'b0, busy}, 32'd0);
    endtask

    // One access from IDLE; the ack is expected on the second negedge after the grant edge.
    task automatic access(input bit port, input bit we, input logic [11:0] addr,
                          input logic [15:0] wd, input logic [15:0] exp_rd, input bit drop_early);
        int we_cnt = 0;
        int re_cnt = 0;
        int lat = -1;
        wait_idle();
        sb.push_back('{port, exp_rd});
        if (port) begin
            we1 = we; addr1 = addr; wdata1 = wd; req1 = 1'b1;
        end else begin
            we0 = we; addr0 = addr; wdata0 = wd; req0 = 1'b1;
        end
        for (int i = 0; i < 10 && lat < 0; i++) begin
            @(negedge CLK);
            if (mem_we) we_cnt++;
            if (mem_re) re_cnt++;
            if (mem_we || mem_re) check("mem_addr", {20'b0, mem_addr}, {20'b0, addr});
            if (drop_early && i == 0) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            if (port ? ack1 : ack0) lat = i;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        check("ack_latency", lat, 32'd1);
        check("we_cycles", we_cnt, we ? 32'd1 : 32'd0);
        check("re_cycles", re_cnt, we ? 32'd0 : 32'd1);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) begin
            @(negedge CLK);
            if (ack0) req0 = 1'b0;
            if (ack1) req1 = 1'b0;
        end
        req0 = 1'b0;
        req1 = 1'b0;
        check("sb_drained", sb.size(), 32'd0);
    endtask

    initial begin
        int n;
        int last;
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        mem[12'h12C] = 16'h11F4;
        mem[12'h300] = 16'h4131;
        mem[12'h0AB] = 16'h7777;
        mem[12'h010] = 16'h0A0A;
        mem[12'h020] = 16'h0B0B;
        do_reset();

        // Port 0 read.
        access(1'b0, 1'b0, 12'h12C, 16'h0, 16'h11F4, 1'b0);

        // Port 1 write keeps rdata1, then read returns written data.
        access(1'b1, 1'b1, 12'h1F7, 16'hBEEF, 16'h0000, 1'b0);
        access(1'b1, 1'b0, 12'h1F7, 16'h0, 16'hBEEF, 1'b0);
        check("rdata0_unchanged", {16'b0, rdata0}, 32'h11F4);

        // req0 dropped in ACCESS: ack still arrives, then arbiter stays idle.
        access(1'b0, 1'b0, 12'h0AB, 16'h0, 16'h7777, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("stay_idle", {31'b0, busy}, 32'd0);
        end

        // Top word write/read.
        access(1'b0, 1'b1, 12'hFFF, 16'h5A5A, 16'h7777, 1'b0);
        access(1'b0, 1'b0, 12'hFFF, 16'h0, 16'h5A5A, 1'b0);

        // Reset during a port 1 write ACCESS aborts it.
        wait_idle();
        we1 = 1'b1; addr1 = 12'h300; wdata1 = 16'hDEAD; req1 = 1'b1;
        @(negedge CLK);
        check("abort_in_access_we", {31'b0, mem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_we_drop", {31'b0, mem_we}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_no_ack", {30'b0, ack1, ack0}, 32'd0);
        req1 = 1'b0;
        @(negedge CLK);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) @(negedge CLK);
        check("abort_mem_kept", {16'b0, mem[12'h300]}, 32'h4131);
        sb.push_back('{1'b0, 16'h11F4});
        sb.push_back('{1'b1, 16'hBEEF});
        we0 = 1'b0; addr0 = 12'h12C; req0 = 1'b1;
        we1 = 1'b0; addr1 = 12'h1F7; req1 = 1'b1;
        drain(20);

        // Continuous dual requests after reset alternate 0,1,0,1 every 3 cycles.
        do_reset();
        sb.push_back('{1'b0, 16'h0A0A});
        sb.push_back('{1'b1, 16'h0B0B});
        sb.push_back('{1'b0, 16'h0A0A});
        sb.push_back('{1'b1, 16'h0B0B});
        we0 = 1'b0; addr0 = 12'h010; req0 = 1'b1;
        we1 = 1'b0; addr1 = 12'h020; req1 = 1'b1;
        n = 0;
        last = 0;
        for (int c = 0; c < 30 && n < 4; c++) begin
            @(negedge CLK);
            if (ack0 || ack1) begin
                if (n > 0) check("rr_interval", c - last, 32'd3);
                last = c;
                n++;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        check("rr_ack_count", n, 32'd4);
        for (int i = 0; i < 4; i++) @(negedge CLK);
        check("final_sb_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
